// File: rtl/decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// decode_ctrl_stage
//
// Registered RV32I/RV64I instruction decoder (optional M-extension) between the
// IF/ID and ID/EX pipeline registers. It decodes combinationally and buffers
// the bundle in a 2-entry skid FIFO, so EX backpressure never drops or
// duplicates an instruction. It also keeps a saturating count of accepted
// illegal instructions.
//
// Parameters
//   XLEN   32 or 64; pc width, store-mask width and legal load/store sizes
//   EN_M   1 enables MUL/DIV decode (funct7 = 0000001 on register-register ops)
//   CNT_W  width of illegal_count
//
// Ports
//   clk, rst (sync, active-high), flush    clock / reset / pipeline flush
//   in_valid, in_ready, in_instr, in_pc    upstream handshake and instruction
//   out_valid, out_ready                   downstream handshake (head entry)
//   out_pc, out_instr                      carried with each entry
//   out_jal .. out_imm_type                decoded control bundle of head entry
//   out_illegal                            head entry is an illegal instruction
//   illegal_count                          saturating count of illegal accepts
// -----------------------------------------------------------------------------
module decode_ctrl_stage #(
    parameter int XLEN  = 32,
    parameter int EN_M  = 0,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [31:0]         out_instr,
    output logic                out_jal,
    output logic                out_jalr,
    output logic                out_load_npc,
    output logic                out_mem_to_reg,
    output logic                out_alu_src1,
    output logic [2:0]          out_reg_write,
    output logic [XLEN/8-1:0]   out_mem_write,
    output logic [1:0]          out_reg_read,
    output logic [2:0]          out_branch_type,
    output logic [4:0]          out_alu_type,
    output logic [1:0]          out_alu_src2,
    output logic [2:0]          out_imm_type,
    output logic                out_illegal,
    output logic [CNT_W-1:0]    illegal_count
);

    localparam int MW = XLEN / 8;

    // Opcodes
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_REGIMM  = 7'b0010011;
    localparam logic [6:0] OP_REGREG  = 7'b0110011;

    // Immediate format encodings
    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] ITYPE    = 3'b001;
    localparam logic [2:0] STYPE    = 3'b010;
    localparam logic [2:0] BTYPE    = 3'b011;
    localparam logic [2:0] UTYPE    = 3'b100;
    localparam logic [2:0] JTYPE    = 3'b101;

    // Register-write size code for full-width results
    localparam logic [2:0] RW_FULL = (XLEN == 64) ? 3'b100 : 3'b011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            jal;
        logic            jalr;
        logic            load_npc;
        logic            mem_to_reg;
        logic            alu_src1;
        logic [2:0]      reg_write;
        logic [MW-1:0]   mem_write;
        logic [1:0]      reg_read;
        logic [2:0]      branch_type;
        logic [4:0]      alu_type;
        logic [1:0]      alu_src2;
        logic [2:0]      imm_type;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;
    logic [MW-1:0] w_store_mask;
    logic          w_imm_alt;
    logic          w_reg_m;
    logic          w_reg_alt;
    entry_t        w_entry;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    // Store byte enables: the low 2^funct3 bytes.
    genvar gi;
    generate
        for (gi = 0; gi < MW; gi++) begin : g_store_mask
            assign w_store_mask[gi] = (gi < (1 << w_funct3));
        end
    endgenerate

    // On RV64 the shift amount occupies bit 25, so only bits 31:26 select SRAI.
    assign w_imm_alt = (w_funct3 == 3'b101) &&
                       ((XLEN == 64) ? (in_instr[31:26] == 6'b010000)
                                     : (w_funct7 == 7'b0100000));
    assign w_reg_m   = (EN_M != 0) && (w_funct7 == 7'b0000001);
    assign w_reg_alt = (w_funct7 == 7'b0100000);

    always_comb begin
        w_entry             = '0;
        w_entry.pc          = in_pc;
        w_entry.instr       = in_instr;
        w_entry.alu_src2    = 2'b10;
        w_entry.imm_type    = IMM_NONE;

        case (w_opcode)
            OP_LUI: begin
                w_entry.reg_write = RW_FULL;
                w_entry.alu_type  = 5'b01011;
                w_entry.imm_type  = UTYPE;
            end
            OP_AUIPC: begin
                w_entry.reg_write = RW_FULL;
                w_entry.alu_src1  = 1'b1;
                w_entry.imm_type  = UTYPE;
            end
            OP_JAL: begin
                w_entry.jal       = 1'b1;
                w_entry.load_npc  = 1'b1;
                w_entry.reg_write = RW_FULL;
                w_entry.imm_type  = JTYPE;
            end
            OP_JALR: begin
                w_entry.jalr      = 1'b1;
                w_entry.load_npc  = 1'b1;
                w_entry.reg_write = RW_FULL;
                w_entry.reg_read  = 2'b01;
                w_entry.imm_type  = ITYPE;
                w_entry.illegal   = (w_funct3 != 3'b000);
            end
            OP_BRANCH: begin
                w_entry.reg_read    = 2'b11;
                w_entry.alu_src2    = 2'b00;
                w_entry.branch_type = w_funct3 - 3'd2;
                w_entry.imm_type    = BTYPE;
                w_entry.illegal     = (w_funct3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                w_entry.reg_write  = w_funct3 + 3'd1;
                w_entry.mem_to_reg = 1'b1;
                w_entry.reg_read   = 2'b01;
                w_entry.imm_type   = ITYPE;
                w_entry.illegal    = (w_funct3 == 3'b111) ||
                                     ((XLEN == 32) && (w_funct3 == 3'b011));
            end
            OP_STORE: begin
                w_entry.mem_write = w_store_mask;
                w_entry.reg_read  = 2'b11;
                w_entry.imm_type  = STYPE;
                w_entry.illegal   = (XLEN == 32) ? (w_funct3 >= 3'b011)
                                                 : (w_funct3 >= 3'b100);
            end
            OP_REGIMM: begin
                w_entry.reg_write = RW_FULL;
                w_entry.reg_read  = 2'b01;
                w_entry.imm_type  = ITYPE;
                w_entry.alu_type  = {1'b0, w_imm_alt, w_funct3};
                // Shift-immediates take a shamt operand rather than the imm.
                w_entry.alu_src2  = (w_funct3[1:0] == 2'b01) ? 2'b01 : 2'b10;
            end
            OP_REGREG: begin
                w_entry.reg_write = RW_FULL;
                w_entry.reg_read  = 2'b11;
                w_entry.alu_src2  = 2'b00;
                w_entry.alu_type  = {w_reg_m, w_reg_alt, w_funct3};
                w_entry.illegal   =
                    !((w_funct7 == 7'b0000000) || w_reg_alt || w_reg_m) ||
                    (w_reg_alt && (w_funct3 != 3'b000) && (w_funct3 != 3'b101));
            end
            default: begin
                w_entry.illegal = 1'b1;
            end
        endcase

        // Illegal entries must not cause any architectural side effect.
        if (w_entry.illegal) begin
            w_entry.reg_write   = 3'b000;
            w_entry.mem_write   = '0;
            w_entry.branch_type = 3'b000;
            w_entry.jal         = 1'b0;
            w_entry.jalr        = 1'b0;
            w_entry.load_npc    = 1'b0;
            w_entry.mem_to_reg  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry skid FIFO
    // ------------------------------------------------------------------
    entry_t           r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_illegal_count;
    logic             w_push;
    logic             w_pop;
    entry_t           w_head;

    // Ready depends only on occupancy, rst and flush: no ready-to-ready path.
    assign in_ready  = (r_count != 2'd2) && !rst && !flush;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= w_entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_illegal_count <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 2'd1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 2'd1;
                end
            end
            // w_push is already blocked during flush, so flushed input is not counted.
            if (w_push && w_entry.illegal && (r_illegal_count != {CNT_W{1'b1}})) begin
                r_illegal_count <= r_illegal_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign out_pc          = w_head.pc;
    assign out_instr       = w_head.instr;
    assign out_jal         = w_head.jal;
    assign out_jalr        = w_head.jalr;
    assign out_load_npc    = w_head.load_npc;
    assign out_mem_to_reg  = w_head.mem_to_reg;
    assign out_alu_src1    = w_head.alu_src1;
    assign out_reg_write   = w_head.reg_write;
    assign out_mem_write   = w_head.mem_write;
    assign out_reg_read    = w_head.reg_read;
    assign out_branch_type = w_head.branch_type;
    assign out_alu_type    = w_head.alu_type;
    assign out_alu_src2    = w_head.alu_src2;
    assign out_imm_type    = w_head.imm_type;
    assign out_illegal     = w_head.illegal;
    assign illegal_count   = r_illegal_count;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_stage
//
// Three decoder instances driven by one shared stimulus stream:
//   _a : XLEN=32, EN_M=0, CNT_W=8
//   _b : XLEN=32, EN_M=1, CNT_W=2
//   _c : XLEN=64, EN_M=1, CNT_W=8
// Directed instruction words with hand-computed expected control values.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = 32'h0;
    logic [63:0] in_pc = 64'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance A outputs
    logic rdy_a, vld_a, jal_a, jalr_a, lnpc_a, m2r_a, src1_a, ill_a;
    logic [31:0] pc_a, ins_a;
    logic [2:0] rw_a, bt_a, it_a;
    logic [3:0] mw_a;
    logic [1:0] rr_a, src2_a;
    logic [4:0] at_a;
    logic [7:0] cnt_a;

    // Instance B outputs
    logic rdy_b, vld_b, jal_b, jalr_b, lnpc_b, m2r_b, src1_b, ill_b;
    logic [31:0] pc_b, ins_b;
    logic [2:0] rw_b, bt_b, it_b;
    logic [3:0] mw_b;
    logic [1:0] rr_b, src2_b;
    logic [4:0] at_b;
    logic [1:0] cnt_b;

    // Instance C outputs
    logic rdy_c, vld_c, jal_c, jalr_c, lnpc_c, m2r_c, src1_c, ill_c;
    logic [63:0] pc_c;
    logic [31:0] ins_c;
    logic [2:0] rw_c, bt_c, it_c;
    logic [7:0] mw_c;
    logic [1:0] rr_c, src2_c;
    logic [4:0] at_c;
    logic [7:0] cnt_c;

    decode_ctrl_stage #(.XLEN(32), .EN_M(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vld_a), .out_ready(out_ready),
        .out_pc(pc_a), .out_instr(ins_a), .out_jal(jal_a), .out_jalr(jalr_a),
        .out_load_npc(lnpc_a), .out_mem_to_reg(m2r_a), .out_alu_src1(src1_a),
        .out_reg_write(rw_a), .out_mem_write(mw_a), .out_reg_read(rr_a),
        .out_branch_type(bt_a), .out_alu_type(at_a), .out_alu_src2(src2_a),
        .out_imm_type(it_a), .out_illegal(ill_a), .illegal_count(cnt_a)
    );

    decode_ctrl_stage #(.XLEN(32), .EN_M(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vld_b), .out_ready(out_ready),
        .out_pc(pc_b), .out_instr(ins_b), .out_jal(jal_b), .out_jalr(jalr_b),
        .out_load_npc(lnpc_b), .out_mem_to_reg(m2r_b), .out_alu_src1(src1_b),
        .out_reg_write(rw_b), .out_mem_write(mw_b), .out_reg_read(rr_b),
        .out_branch_type(bt_b), .out_alu_type(at_b), .out_alu_src2(src2_b),
        .out_imm_type(it_b), .out_illegal(ill_b), .illegal_count(cnt_b)
    );

    decode_ctrl_stage #(.XLEN(64), .EN_M(1), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld_c), .out_ready(out_ready),
        .out_pc(pc_c), .out_instr(ins_c), .out_jal(jal_c), .out_jalr(jalr_c),
        .out_load_npc(lnpc_c), .out_mem_to_reg(m2r_c), .out_alu_src1(src1_c),
        .out_reg_write(rw_c), .out_mem_write(mw_c), .out_reg_read(rr_c),
        .out_branch_type(bt_c), .out_alu_type(at_c), .out_alu_src2(src2_c),
        .out_imm_type(it_c), .out_illegal(ill_c), .illegal_count(cnt_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one instruction for one clock edge; one line per transaction.
    task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        $display("txn instr=%08h pc=%0h out_ready=%0b head_valid=%0b head_pc=%0h",
                 instr, pc, out_ready, vld_a, pc_a);
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_in_ready",  64'(rdy_a), 64'(0));
        chk("rst_out_valid", 64'(vld_a), 64'(0));
        chk("rst_count",     64'(cnt_a), 64'(0));
        chk("rst_reg_write", 64'(rw_a),  64'(0));
        chk("rst_pc",        64'(pc_c),  64'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(rdy_a), 64'(1));

        // ---------------- ADD x1,x2,x3 ----------------
        offer(32'h003100B3, 64'h100);
        chk("add_valid", 64'(vld_a),  64'(1));
        chk("add_alu",   64'(at_a),   64'(0));
        chk("add_rr",    64'(rr_a),   64'(3));
        chk("add_rw",    64'(rw_a),   64'(3));
        chk("add_src2",  64'(src2_a), 64'(0));
        chk("add_ill",   64'(ill_a),  64'(0));
        chk("add_pc",    64'(pc_a),   64'('h100));
        chk("add_rw64",  64'(rw_c),   64'(4));

        // ---------------- MUL ----------------
        offer(32'h023100B3, 64'h104);
        chk("mul_m_alu", 64'(at_b),  64'(5'b10000));
        chk("mul_m_ill", 64'(ill_b), 64'(0));
        chk("mul_noM_ill",   64'(ill_a), 64'(1));
        chk("mul_noM_rw",    64'(rw_a),  64'(0));
        chk("mul_noM_count", 64'(cnt_a), 64'(1));
        chk("mul_m_count",   64'(cnt_b), 64'(0));
        chk("mul_instr",     64'(ins_a), 64'('h023100B3));

        // ---------------- stores ----------------
        offer(32'h00310023, 64'h108);          // SB
        chk("sb_mw",  64'(mw_a), 64'(4'b0001));
        chk("sb_rw",  64'(rw_a), 64'(0));
        chk("sb_it",  64'(it_a), 64'(2));
        offer(32'h00312023, 64'h10C);          // SW
        chk("sw_mw",   64'(mw_a), 64'(4'b1111));
        chk("sw_mw64", 64'(mw_c), 64'(8'h0F));
        offer(32'h00313023, 64'h110);          // SD
        chk("sd_mw64",   64'(mw_c),  64'(8'hFF));
        chk("sd_ill64",  64'(ill_c), 64'(0));
        chk("sd_ill32",  64'(ill_a), 64'(1));
        chk("sd_mw32",   64'(mw_a),  64'(0));
        chk("sd_count",  64'(cnt_a), 64'(2));

        // ---------------- branch / load ----------------
        offer(32'h00317063, 64'h114);          // BGEU
        chk("bgeu_bt",   64'(bt_a),   64'(3'b101));
        chk("bgeu_rw",   64'(rw_a),   64'(0));
        chk("bgeu_src2", 64'(src2_a), 64'(0));
        chk("bgeu_it",   64'(it_a),   64'(3));
        offer(32'h00015083, 64'h118);          // LHU x1,0(x2)
        chk("lhu_rw",   64'(rw_a),   64'(3'b110));
        chk("lhu_m2r",  64'(m2r_a),  64'(1));
        chk("lhu_src2", 64'(src2_a), 64'(2));
        chk("lhu_it",   64'(it_a),   64'(1));

        // ---------------- LUI / JAL / SRAI ----------------
        offer(32'h123450B7, 64'h11C);          // LUI
        chk("lui_alu", 64'(at_a), 64'(5'b01011));
        chk("lui_rw",  64'(rw_a), 64'(3));
        offer(32'h0080006F, 64'h120);          // JAL x0,8
        chk("jal_jal",  64'(jal_a),  64'(1));
        chk("jal_npc",  64'(lnpc_a), 64'(1));
        chk("jal_it",   64'(it_a),   64'(5));
        offer(32'h4030D093, 64'h124);          // SRAI x1,x1,3
        chk("srai_alu",   64'(at_a),   64'(5'b01101));
        chk("srai_src2",  64'(src2_a), 64'(1));
        chk("srai_alu64", 64'(at_c),   64'(5'b01101));

        // drain
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(vld_a), 64'(0));

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        offer(32'h003100B3, 64'h200);
        chk("bp1_ready", 64'(rdy_a), 64'(1));
        chk("bp1_pc",    64'(pc_a),  64'('h200));
        offer(32'h003100B3, 64'h204);
        chk("bp2_ready", 64'(rdy_a), 64'(0));
        chk("bp2_pc",    64'(pc_a),  64'('h200));
        offer(32'h003100B3, 64'h208);
        chk("bp3_held_pc", 64'(pc_a),  64'('h200));
        chk("bp3_ready",   64'(rdy_a), 64'(0));
        out_ready = 1'b1;
        offer(32'h003100B3, 64'h208);
        chk("bp_pop1_pc", 64'(pc_a), 64'('h204));
        offer(32'h003100B3, 64'h208);
        chk("bp_pop2_pc", 64'(pc_a), 64'('h208));
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(vld_a), 64'(0));

        // ---------------- flush ----------------
        out_ready = 1'b0;
        offer(32'h003100B3, 64'h300);
        offer(32'h003100B3, 64'h304);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        in_pc    = 64'h3FC;
        #1;
        chk("flush_in_ready", 64'(rdy_a), 64'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_valid", 64'(vld_a), 64'(0));
        chk("flush_ready", 64'(rdy_a), 64'(1));
        chk("flush_count", 64'(cnt_a), 64'(2));
        out_ready = 1'b1;
        tick();
        chk("flush_not_emitted", 64'(vld_a), 64'(0));

        // ---------------- saturation ----------------
        rst = 1'b1;
        tick();
        chk("rst2_count_a", 64'(cnt_a), 64'(0));
        chk("rst2_count_b", 64'(cnt_b), 64'(0));
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            offer(32'hFFFFFFFF, 64'(32'h400 + 4 * k));
            chk($sformatf("sat_b_%0d", k), 64'(cnt_b), 64'((k > 3) ? 3 : k));
            chk($sformatf("sat_a_%0d", k), 64'(cnt_a), 64'(k));
            chk($sformatf("sat_ill_%0d", k), 64'(ill_b), 64'(1));
        end
        chk("ill_jal", 64'(jal_b), 64'(0));
        chk("ill_rw",  64'(rw_b),  64'(0));
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(rdy_a), 64'(0));
        tick();
        chk("rst_mid_count", 64'(cnt_b), 64'(0));
        chk("rst_mid_valid", 64'(vld_b), 64'(0));
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
